// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands summed CHUNK bits per clock,
// LSB chunk first, with a registered carry and valid/ready handshakes on both sides.
module chunked_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] M_i,
    input  logic [WIDTH-1:0] N_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH:0]   result_o,
    output logic             overflow_o
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]    LAST_CHUNK = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_cout;
    logic             r_ovf;

    logic [31:0]      w_shamt;
    logic [CHUNK-1:0] w_m_chunk;
    logic [CHUNK-1:0] w_n_chunk;
    logic [CHUNK:0]   w_chunk_sum;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_msb_cin;
    logic             w_last;

    // Chunk slice selected by the counter; the sum bits are merged back in place.
    assign w_shamt     = 32'(r_cnt) * CHUNK;
    assign w_m_chunk   = CHUNK'(r_m >> w_shamt);
    assign w_n_chunk   = CHUNK'(r_n >> w_shamt);
    assign w_chunk_sum = {1'b0, w_m_chunk} + {1'b0, w_n_chunk} + {{CHUNK{1'b0}}, r_carry};
    assign w_sum_next  = (r_sum & ~(CHUNK_MASK << w_shamt))
                       | (WIDTH'(w_chunk_sum[CHUNK-1:0]) << w_shamt);
    assign w_last      = (r_cnt == LAST_CHUNK);

    // Carry into the operand MSB recovered from the MSB sum bit and its inputs.
    assign w_msb_cin = w_m_chunk[CHUNK-1] ^ w_n_chunk[CHUNK-1] ^ w_chunk_sum[CHUNK-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_n     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_m     <= M_i;
                        r_n     <= sub_i ? ~N_i : N_i;
                        r_carry <= sub_i | cin_i;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_chunk_sum[CHUNK];
                    if (w_last) begin
                        r_cout  <= w_chunk_sum[CHUNK];
                        r_ovf   <= w_msb_cin ^ w_chunk_sum[CHUNK];
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready_o    = (r_state == S_IDLE);
    assign valid_o    = (r_state == S_DONE);
    assign result_o   = {r_cout, r_sum};
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: three configurations (8/4, 16/4, 8/8) checked against
// a signed/unsigned arithmetic reference model, plus backpressure and reset cases.
module tb_chunked_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] m_s, n_s;
    logic        cin_s, sub_s, rdy_in;
    logic [2:0]  vin, rdy_o, vout, ovf;
    logic [8:0]  res0, res2;
    logic [16:0] res1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(8), .CHUNK(4)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vin[0]), .ready_o(rdy_o[0]),
        .M_i(m_s[7:0]), .N_i(n_s[7:0]), .cin_i(cin_s), .sub_i(sub_s),
        .valid_o(vout[0]), .ready_i(rdy_in), .result_o(res0), .overflow_o(ovf[0]));

    chunked_adder #(.WIDTH(16), .CHUNK(4)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vin[1]), .ready_o(rdy_o[1]),
        .M_i(m_s), .N_i(n_s), .cin_i(cin_s), .sub_i(sub_s),
        .valid_o(vout[1]), .ready_i(rdy_in), .result_o(res1), .overflow_o(ovf[1]));

    chunked_adder #(.WIDTH(8), .CHUNK(8)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vin[2]), .ready_o(rdy_o[2]),
        .M_i(m_s[7:0]), .N_i(n_s[7:0]), .cin_i(cin_s), .sub_i(sub_s),
        .valid_o(vout[2]), .ready_i(rdy_in), .result_o(res2), .overflow_o(ovf[2]));

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] res(input int sel);
        case (sel)
            0:       return {8'd0, res0};
            1:       return res1;
            default: return {8'd0, res2};
        endcase
    endfunction

    function automatic int width_of(input int sel);
        return (sel == 1) ? 16 : 8;
    endfunction

    function automatic int nchunk_of(input int sel);
        return (sel == 0) ? 2 : (sel == 1) ? 4 : 1;
    endfunction

    // Reference: unsigned result with carry/no-borrow in bit w; overflow from true signed value.
    task automatic model(input int w, input logic [15:0] m, input logic [15:0] n,
                         input logic cin, input logic sub,
                         output logic [16:0] r, output logic o);
        longint mask, um, un, full, sm, sn, tv, half;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        um   = longint'(m) & mask;
        un   = longint'(n) & mask;
        full = sub ? (um - un + (mask + 1)) : (um + un + longint'(cin));
        r    = 17'(full & ((mask << 1) | 1));
        sm   = (um >= half) ? um - (mask + 1) : um;
        sn   = (un >= half) ? un - (mask + 1) : un;
        tv   = sub ? (sm - sn) : (sm + sn + longint'(cin));
        o    = (tv < -half) || (tv > half - 1);
    endtask

    task automatic wait_valid(input int sel, output int lat);
        lat = 0;
        while (!vout[sel] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input int sel, input logic [15:0] m, input logic [15:0] n,
                         input logic cin, input logic sub);
        logic [16:0] exp_r;
        logic        exp_o;
        int          lat;
        model(width_of(sel), m, n, cin, sub, exp_r, exp_o);
        lat = 0;
        while (!rdy_o[sel] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ready_before", rdy_o[sel], 1);
        @(negedge clk);
        m_s = m; n_s = n; cin_s = cin; sub_s = sub; vin[sel] = 1'b1;
        @(posedge clk); #1;
        vin[sel] = 1'b0;
        check("ready_busy", rdy_o[sel], 0);
        wait_valid(sel, lat);
        check("latency", lat, nchunk_of(sel));
        check("result", res(sel), exp_r);
        check("overflow", ovf[sel], exp_o);
        @(posedge clk); #1;
        check("back_idle", {vout[sel], rdy_o[sel]}, 2'b01);
    endtask

    initial begin
        logic [16:0] held;
        int          lat;
        logic        seen;
        rst_n = 1'b0; vin = '0; m_s = '0; n_s = '0; cin_s = 0; sub_s = 0; rdy_in = 1'b1;
        #12;
        for (int s = 0; s < 3; s++) begin
            check("rst_result", res(s), 0);
            check("rst_flags", {vout[s], ovf[s], rdy_o[s]}, 3'b001);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases, 8-bit / 4-bit chunks
        do_op(0, 16'h5A, 16'h3C, 1'b0, 1'b0);
        do_op(0, 16'hFF, 16'h01, 1'b0, 1'b0);
        do_op(0, 16'hFF, 16'hFF, 1'b1, 1'b0);
        do_op(0, 16'h7F, 16'h01, 1'b0, 1'b0);
        do_op(0, 16'h10, 16'h20, 1'b1, 1'b1);
        do_op(0, 16'h80, 16'h01, 1'b0, 1'b1);

        // Backpressure with a request held during DONE
        @(negedge clk);
        m_s = 16'h5A; n_s = 16'h3C; cin_s = 0; sub_s = 0; rdy_in = 1'b0; vin[0] = 1'b1;
        @(posedge clk); #1;
        vin[0] = 1'b0;
        wait_valid(0, lat);
        check("bp_latency", lat, 2);
        held = res(0);
        check("bp_first", held, 17'h096);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", vout[0], 1);
            check("bp_result", res(0), held);
            check("bp_ready", rdy_o[0], 0);
            if (i == 1) begin
                m_s = 16'h11; n_s = 16'h22; vin[0] = 1'b1;
            end
        end
        @(negedge clk);
        rdy_in = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {vout[0], rdy_o[0]}, 2'b01);
        @(posedge clk); #1;
        check("bp_accept", rdy_o[0], 0);
        vin[0] = 1'b0;
        wait_valid(0, lat);
        check("bp_next_lat", lat, 2);
        check("bp_next", res(0), 17'h033);
        @(posedge clk); #1;

        // Reset while mid-CALC
        @(negedge clk);
        m_s = 16'h5A; n_s = 16'h3C; cin_s = 0; sub_s = 0; vin[0] = 1'b1;
        @(posedge clk); #1;
        vin[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_result", res(0), 0);
        check("mid_rst_flags", {vout[0], ovf[0], rdy_o[0]}, 3'b001);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | vout[0];
        end
        check("no_valid_after_rst", seen, 0);
        do_op(0, 16'h01, 16'h01, 1'b0, 1'b0);

        // Other configurations
        do_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_op(2, 16'h12, 16'h34, 1'b0, 1'b0);

        // Randomized back-to-back operations on every configuration
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 25; k++) begin
                do_op(s, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
